// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Select-index to active-low one-hot decoder for multiplexed digit/row drivers.
//   In manual mode a software-written index is applied; in auto mode an internal
//   prescaler steps the index round-robin. Every channel change inserts an
//   all-off blanking interval so adjacent channels never ghost.
//
// Ports
//   clk    : single clock, rising-edge
//   rst_n  : synchronous reset, active low
//   en     : output enable (0 forces all outputs off)
//   mode   : 0 = manual select, 1 = auto scan
//   sel    : manual channel index
//   load   : one-cycle strobe capturing sel in manual mode
//   y_n    : active-low one-hot channel select (registered)
//   idx    : current channel index (registered)
//   tick   : one-cycle pulse when auto scan advances idx (registered)
//
// State | meaning
//   OFF   | outputs all off, waiting for en
//   BLANK | outputs all off, blank counter running down
//   ON    | channel idx driven low
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int SEL_W    = 2,
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 250,
  parameter int BLANK    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              load,
  output logic [NUM_CH-1:0] y_n,
  output logic [SEL_W-1:0]  idx,
  output logic              tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // The blank counter holds BLANK-1 down to 0, so it only needs to reach BLANK-1.
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0]    BLANK_LD = BW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [NUM_CH-1:0] y_n_q, y_n_d;
  logic              tick_q, tick_d;
  logic              mode_q;

  logic              sel_ok;
  logic              mode_chg;
  logic              go_blank;
  logic [SEL_W-1:0]  idx_next;

  // A manual load only matters when it names a real, different channel.
  assign sel_ok   = load && !mode && (sel <= LAST_CH) && (sel != idx_q);
  assign mode_chg = (mode != mode_q);
  assign idx_next = (idx_q == LAST_CH) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    blank_d  = blank_q;
    tick_d   = 1'b0;
    go_blank = 1'b0;

    if (!en) begin
      // Disable wins over everything; a manual index may still be staged.
      state_d = S_OFF;
      presc_d = '0;
      if (sel_ok) idx_d = sel;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (sel_ok) idx_d = sel;
          go_blank = 1'b1;
        end
        S_BLANK: begin
          if (sel_ok) begin
            idx_d    = sel;
            go_blank = 1'b1;
          end else if (blank_q == '0) begin
            state_d = S_ON;
          end else begin
            blank_d = blank_q - 1'b1;
          end
        end
        S_ON: begin
          if (sel_ok) begin
            idx_d    = sel;
            go_blank = 1'b1;
          end else if (mode && !mode_chg) begin
            if (presc_q == PRE_LAST) begin
              idx_d    = idx_next;
              tick_d   = 1'b1;
              presc_d  = '0;
              go_blank = 1'b1;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        default: state_d = S_OFF;
      endcase

      if (go_blank) begin
        if (BLANK == 0) begin
          state_d = S_ON;
        end else begin
          state_d = S_BLANK;
          blank_d = BLANK_LD;
        end
      end
    end

    // Prescaler only runs in auto mode and restarts on any mode switch.
    if (!mode || mode_chg) presc_d = '0;

    // Outputs are registered from the next state so they track state exactly.
    for (int i = 0; i < NUM_CH; i++) begin
      y_n_d[i] = !((state_d == S_ON) && (idx_d == SEL_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      presc_q <= '0;
      blank_q <= '0;
      y_n_q   <= '1;
      tick_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
      y_n_q   <= y_n_d;
      tick_q  <= tick_d;
      mode_q  <= mode;
    end
  end

  assign y_n  = y_n_q;
  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, load;
  logic [1:0] sel;

  logic [3:0] ya, yb;
  logic [2:0] yc;
  logic [1:0] idxa, idxb, idxc;
  logic       ticka, tickb, tickc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Defaults: 4 channels, PRESCALE=250, BLANK=2
  scan_decoder #(.SEL_W(2), .NUM_CH(4), .PRESCALE(250), .BLANK(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .y_n(ya), .idx(idxa), .tick(ticka));

  // Fast auto scan: PRESCALE=4, BLANK=1
  scan_decoder #(.SEL_W(2), .NUM_CH(4), .PRESCALE(4), .BLANK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .y_n(yb), .idx(idxb), .tick(tickb));

  // Boundary: 3 channels on a 2-bit index
  scan_decoder #(.SEL_W(2), .NUM_CH(3), .PRESCALE(2), .BLANK(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .y_n(yc), .idx(idxc), .tick(tickc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd0; load = 1'b0;
    step(); step();
    checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL reset_y got %b want 1111", ya); end
    checks++; if (idxa !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idxa); end
    checks++; if (ticka !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", ticka); end
    rst_n = 1'b1;
    step();
    checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL release_blank0 got %b want 1111", ya); end
    step();
    checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL release_blank1 got %b want 1111", ya); end
    step();
    checks++; if (ya !== 4'b1110) begin errors++; $display("FAIL release_on got %b want 1110", ya); end
  endtask

  task automatic test_manual();
    logic [1:0] sels [4];
    logic [3:0] exps [4];
    sels = '{2'd1, 2'd2, 2'd3, 2'd0};
    exps = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int i = 0; i < 4; i++) begin
      sel = sels[i]; load = 1'b1;
      step();
      load = 1'b0;
      checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL manual_blank0[%0d] got %b want 1111", i, ya); end
      checks++; if (idxa !== sels[i]) begin errors++; $display("FAIL manual_idx[%0d] got %0d want %0d", i, idxa, sels[i]); end
      step();
      checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL manual_blank1[%0d] got %b want 1111", i, ya); end
      step();
      checks++; if (ya !== exps[i]) begin errors++; $display("FAIL manual_on[%0d] got %b want %b", i, ya, exps[i]); end
      step();
      checks++; if (ya !== exps[i]) begin errors++; $display("FAIL manual_hold[%0d] got %b want %b", i, ya, exps[i]); end
      checks++; if (ticka !== 1'b0) begin errors++; $display("FAIL manual_tick[%0d] got %b want 0", i, ticka); end
    end
    // Reloading the current index must not blank
    sel = 2'd0; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (ya !== 4'b1110) begin errors++; $display("FAIL same_sel_y got %b want 1110", ya); end
    checks++; if (idxa !== 2'd0) begin errors++; $display("FAIL same_sel_idx got %0d want 0", idxa); end
    step();
    checks++; if (ya !== 4'b1110) begin errors++; $display("FAIL same_sel_hold got %b want 1110", ya); end
  endtask

  task automatic test_disable_mid_blank();
    sel = 2'd2; load = 1'b1;
    step();
    load = 1'b0; en = 1'b0;
    step();
    checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL dis_y got %b want 1111", ya); end
    checks++; if (idxa !== 2'd2) begin errors++; $display("FAIL dis_idx got %0d want 2", idxa); end
    step();
    checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL dis_hold got %b want 1111", ya); end
    en = 1'b1;
    step();
    checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL reen_blank0 got %b want 1111", ya); end
    step();
    checks++; if (ya !== 4'b1111) begin errors++; $display("FAIL reen_blank1 got %b want 1111", ya); end
    step();
    checks++; if (ya !== 4'b1011) begin errors++; $display("FAIL reen_on got %b want 1011", ya); end
  endtask

  task automatic test_auto();
    logic [3:0] tbl [4];
    tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    mode = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (yb !== 4'b1111) begin errors++; $display("FAIL auto_start_blank got %b want 1111", yb); end
    step();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (yb !== tbl[i]) begin errors++; $display("FAIL auto_dwell[%0d.%0d] got %b want %b", i, c, yb, tbl[i]); end
        checks++; if (tickb !== 1'b0) begin errors++; $display("FAIL auto_notick[%0d.%0d] got %b want 0", i, c, tickb); end
        step();
      end
      checks++; if (yb !== 4'b1111) begin errors++; $display("FAIL auto_blank[%0d] got %b want 1111", i, yb); end
      checks++; if (tickb !== 1'b1) begin errors++; $display("FAIL auto_tick[%0d] got %b want 1", i, tickb); end
      checks++; if (idxb !== 2'((i + 1) % 4)) begin errors++; $display("FAIL auto_idx[%0d] got %0d want %0d", i, idxb, (i + 1) % 4); end
      step();
    end
    checks++; if (yb !== 4'b1110) begin errors++; $display("FAIL auto_wrap got %b want 1110", yb); end
  endtask

  task automatic test_reset_mid_dwell();
    // From first cycle of ON idx0: 15 cycles to reach idx3, 2 more for prescaler=2
    for (int i = 0; i < 17; i++) step();
    checks++; if (yb !== 4'b0111) begin errors++; $display("FAIL middwell_pre_y got %b want 0111", yb); end
    checks++; if (idxb !== 2'd3) begin errors++; $display("FAIL middwell_pre_idx got %0d want 3", idxb); end
    rst_n = 1'b0;
    step();
    checks++; if (yb !== 4'b1111) begin errors++; $display("FAIL middwell_y got %b want 1111", yb); end
    checks++; if (idxb !== 2'd0) begin errors++; $display("FAIL middwell_idx got %0d want 0", idxb); end
    checks++; if (tickb !== 1'b0) begin errors++; $display("FAIL middwell_tick got %b want 0", tickb); end
    rst_n = 1'b1;
    step(); step();
    checks++; if (yb !== 4'b1110) begin errors++; $display("FAIL middwell_on got %b want 1110", yb); end
    step(); step(); step();
    checks++; if (yb !== 4'b1110 || tickb !== 1'b0) begin errors++; $display("FAIL middwell_full_dwell got y=%b tick=%b want y=1110 tick=0", yb, tickb); end
    step();
    checks++; if (tickb !== 1'b1 || idxb !== 2'd1) begin errors++; $display("FAIL middwell_advance got tick=%b idx=%0d want tick=1 idx=1", tickb, idxb); end
  endtask

  task automatic test_boundary();
    logic [2:0] ey [10];
    logic       et [10];
    ey = '{3'b011, 3'b011, 3'b111, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b111, 3'b011};
    et = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    checks++; if (yc !== 3'b110) begin errors++; $display("FAIL bnd_on got %b want 110", yc); end
    sel = 2'd3; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (yc !== 3'b110) begin errors++; $display("FAIL bnd_oob_y got %b want 110", yc); end
    checks++; if (idxc !== 2'd0) begin errors++; $display("FAIL bnd_oob_idx got %0d want 0", idxc); end
    step();
    checks++; if (yc !== 3'b110) begin errors++; $display("FAIL bnd_oob_hold got %b want 110", yc); end
    sel = 2'd2; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (yc !== 3'b111 || idxc !== 2'd2) begin errors++; $display("FAIL bnd_load2 got y=%b idx=%0d want y=111 idx=2", yc, idxc); end
    step();
    checks++; if (yc !== 3'b011) begin errors++; $display("FAIL bnd_ch2 got %b want 011", yc); end
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (yc !== ey[i] || tickc !== et[i]) begin errors++; $display("FAIL bnd_auto[%0d] got y=%b tick=%b want y=%b tick=%b", i, yc, tickc, ey[i], et[i]); end
      if (i == 2) begin
        checks++; if (idxc !== 2'd0) begin errors++; $display("FAIL bnd_wrap_idx got %0d want 0", idxc); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 2'd0; load = 1'b0;
    #1;
    test_reset();
    test_manual();
    test_disable_mid_blank();
    test_auto();
    test_reset_mid_dwell();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised N-to-NUM_CH decoder with registered active-low one-hot outputs, for driving multiplexed digit/row selects.
- Manual mode: a software-written select index is applied.
- Auto mode: an internal prescaler steps the index round-robin.
- Every channel change inserts a programmable all-off blanking interval to prevent ghosting.
- Sits between the control/register logic and the display/row driver pins.

Parameters:
SEL_W, 2, width of select index; NUM_CH <= 2^SEL_W
NUM_CH, 4, number of decoded active-low outputs (2..2^SEL_W)
PRESCALE, 250, clk cycles each channel is driven in auto mode (>=1)
BLANK, 2, clk cycles all outputs are off between channel changes (0 = no blanking)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active low
en  input  1  output enable; 0 forces all outputs inactive
mode  input  1  0 = manual select, 1 = auto scan
sel  input  SEL_W  manual channel index
load  input  1  one-cycle strobe; captures sel in manual mode
y_n  output  NUM_CH  active-low one-hot channel select, registered
idx  output  SEL_W  current channel index, registered
tick  output  1  one-cycle pulse when auto scan advances idx

Behaviour:
- Reset (rst_n=0 at an edge): y_n = all ones, idx = 0, tick = 0, prescaler = 0, blank counter = 0, state = OFF. Reset mid-operation aborts any blank/dwell immediately at that edge.
- States:
  - OFF: y_n all ones. Entered whenever en=0.
  - BLANK: y_n all ones; counts BLANK cycles.
  - ON: y_n = ~(1 << idx).
- y_n and idx are registers reflecting the state after each edge; there is no combinational path from inputs to outputs.
- Bits of y_n at or above NUM_CH do not exist. All positions other than idx are 1 in ON.
- OFF -> BLANK on the edge where en=1 is sampled. If BLANK=0, go directly to ON instead.
- BLANK -> ON after BLANK cycles in BLANK. For an event sampled at edge k:
  - y_n is all ones after edges k .. k+BLANK-1.
  - y_n is one-hot after edge k+BLANK.
- Any state -> OFF on the edge where en=0 is sampled, including mid-BLANK. Prescaler clears; idx is held.
- Manual mode (mode=0):
  - load=1 with sel < NUM_CH and sel != idx: idx <= sel.
    - If state is ON or BLANK: enter BLANK and restart the blank counter.
    - If state is OFF: idx updates; outputs stay off.
  - load with sel >= NUM_CH: ignored entirely.
  - load with sel == idx: no effect, no blanking.
  - Prescaler is held at 0.
- Auto mode (mode=1):
  - In ON, prescaler counts 0..PRESCALE-1.
  - On the edge where prescaler == PRESCALE-1:
    - idx <= idx+1, wrapping NUM_CH-1 -> 0;
    - tick = 1 for exactly that cycle;
    - prescaler <= 0;
    - state <= BLANK, or stays ON if BLANK=0.
  - Prescaler does not count in OFF or BLANK.
  - load is ignored in auto mode.
- Mode change (any edge where mode differs from the previous sampled value): prescaler clears; idx and state are unaffected.
- Simultaneous events:
  - en=0 beats everything except reset.
  - In manual mode, load and en rising on the same edge: idx takes sel and state enters BLANK (single blank period).
- tick is 0 at all other times, including in manual mode.

Test Plan:
- Reset with en=1, mode=0 held, rst_n=0 for 2 cycles -> y_n=4'b1111, idx=0, tick=0. Release rst_n -> y_n=1111 for 2 cycles (BLANK=2), then y_n=4'b1110.
- Manual sweep (defaults): load sel=1,2,3,0, each held ≥4 cycles apart -> each load gives 2 cycles of 1111, then 1101, 1011, 0111, 1110 respectively. load sel=idx -> no blanking, y_n unchanged.
- Auto scan with PRESCALE=4, BLANK=1, mode=1, en=1 -> per channel: 4 cycles of one-hot, then 1 cycle of 1111. Sequence 1110,1101,1011,0111,1110 (wrap). tick pulses once per advance, coincident with idx change.
- Disable mid-blank: en=0 during BLANK -> y_n=1111 next edge, idx held. en=1 again -> full 2-cycle blank, then same channel driven.
- Reset mid-dwell in auto mode at prescaler=2, idx=3 -> next edge y_n=1111, idx=0, prescaler=0, tick=0.
- Boundary, NUM_CH=3, SEL_W=2, manual: load sel=3 -> ignored, idx unchanged, no blank. Auto wrap 2->0 and y_n[2:0] cycles 110,101,011.
